// File: rtl/mbe_mul_arbiter.sv
// Round-robin front end for one shared fixed-latency multiplier: grants one
// requester per cycle and routes each product back to its issuer by tag.
module mbe_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_valid,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     busy,
    input  logic                     en
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: lane i transfers on req_valid[i] & req_ready[i]; req_ready is a
    // one-hot grant that never asserts without req_valid. Responses carry no
    // ready and must be taken in the cycle rsp_valid pulses.
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant_idx;
    logic             grant_found;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    issue_id;
    logic [MUL_LAT-1:0] tag_v;
    logic [PW-1:0]    tag_id [MUL_LAT];

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_found && en && !rst && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PW-1:0];
            end
        end
        if (grant_found) grant[grant_idx] = 1'b1;
    end

    assign req_ready = grant;

    // The issue register travels with mul_valid; the tag then needs MUL_LAT
    // more stages so its last stage lines up with mul_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_valid <= 1'b0;
            issue_id  <= '0;
            tag_v     <= '0;
            for (int k = 0; k < MUL_LAT; k++) tag_id[k] <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            mul_valid <= grant_found;
            if (grant_found) begin
                mul_a    <= req_a[grant_idx*WIDTH +: WIDTH];
                mul_b    <= req_b[grant_idx*WIDTH +: WIDTH];
                issue_id <= grant_idx;
                ptr      <= (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            tag_v[0]  <= mul_valid;
            tag_id[0] <= issue_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            rsp_valid <= '0;
            if (tag_v[MUL_LAT-1]) begin
                rsp_valid[tag_id[MUL_LAT-1]] <= 1'b1;
                rsp_p                        <= mul_p;
            end
        end
    end

    assign busy = mul_valid | (|tag_v) | (|rsp_valid);

endmodule

// File: tb/tb_mbe_mul_arbiter.sv
// Directed bench for mbe_mul_arbiter with a behavioural 2-stage multiplier and
// an expected-response queue drained by a negedge monitor.
module tb_mbe_mul_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_valid;
    logic [2*W-1:0] mul_p;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_p;
    logic           busy;
    logic           en;

    int n_cmp = 0;
    int n_err = 0;
    logic [N+2*W-1:0] exp_q[$];
    logic [2*W-1:0]   exp_p [N];
    logic [2*W-1:0]   p_pipe [2];

    mbe_mul_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
        .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy), .en(en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p_pipe[0] <= $signed(mul_a) * $signed(mul_b);
        p_pipe[1] <= p_pipe[0];
    end
    assign mul_p = p_pipe[1];

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N+2*W-1:0] e;
        if (rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e[N+2*W-1:2*W]));
                check("rsp_p", rsp_p, e[2*W-1:0]);
            end
        end
    end

    task automatic set_op(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p);
        req_a[lane*W +: W] = a;
        req_b[lane*W +: W] = b;
        exp_p[lane]        = p;
    endtask

    // Presents req_valid for one cycle; lane < 0 means no grant is expected.
    task automatic issue(input logic [N-1:0] v, input int lane);
        logic [N-1:0] g;
        req_valid = v;
        g = (lane < 0) ? '0 : N'(1 << lane);
        @(negedge clk);
        check("grant", 64'(req_ready), 64'(g));
        if (lane >= 0) exp_q.push_back({g, exp_p[lane]});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int guard;
        req_valid = '0;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_timeout", 64'(guard >= 50), 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) exp_p[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_mul_valid", 64'(mul_valid), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_rsp_p", rsp_p, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // single requester, latency and busy window
        set_op(0, 32'd7, -32'sd3, -64'sd21);
        issue(4'b0001, 0);
        req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("lat_rsp", 64'(rsp_valid), (c == 4) ? 64'd1 : 64'd0);
            check("lat_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("lat_busy_end", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // full contention from pointer 0
        do_reset();
        set_op(0, 32'd2,    -32'sd5,   -64'sd10);
        set_op(1, 32'd3,     32'd6,     64'd18);
        set_op(2, -32'sd4,   32'd7,    -64'sd28);
        set_op(3, 32'd100,  -32'sd100, -64'sd10000);
        for (int k = 0; k < 8; k++) issue(4'b1111, k % 4);
        drain();

        // wrap and skip: move pointer to 3, then only lanes 1 and 3
        do_reset();
        set_op(1, 32'd5,    32'd5,    64'd25);
        set_op(2, 32'd3,    32'd3,    64'd9);
        set_op(3, -32'sd1, -32'sd1,   64'd1);
        issue(4'b0100, 2);
        issue(4'b1010, 3);
        issue(4'b1010, 1);
        issue(4'b1010, 3);
        drain();

        // boundary operands
        set_op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        set_op(1, 32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF);
        issue(4'b0001, 0);
        issue(4'b0010, 1);
        drain();

        // reset one cycle before the first response
        do_reset();
        set_op(0, 32'd11, 32'd11, 64'd121);
        set_op(1, 32'd12, 32'd12, 64'd144);
        set_op(2, 32'd13, 32'd13, 64'd169);
        issue(4'b0111, 0);
        issue(4'b0111, 1);
        issue(4'b0111, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_rsp", 64'(rsp_valid), 64'd0);
        check("post_rst_mul_valid", 64'(mul_valid), 64'd0);
        check("post_rst_mul_a", 64'(mul_a), 64'd0);
        check("post_rst_rsp_p", rsp_p, 64'd0);
        repeat (6) @(posedge clk);
        #1;

        // en gating while two ops drain
        set_op(0, 32'd6,    32'd7, 64'd42);
        set_op(1, -32'sd8,  32'd9, -64'sd72);
        issue(4'b0001, 0);
        issue(4'b0010, 1);
        en = 1'b0;
        req_valid = 4'b1111;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check("en_ready", 64'(req_ready), 64'd0);
            check("en_busy", 64'(busy), (c <= 5) ? 64'd1 : 64'd0);
        end
        req_valid = '0;
        en = 1'b1;
        @(posedge clk); #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
